// File: rtl/rgb_sram_writer.sv
// Clips signed RGB pixels to 8 bits, packs pixel pairs into three 16-bit words
// and streams them through a small FIFO into the RGB region of the external SRAM.
//
// state | meaning
// IDLE  | waiting for start after reset
// RUN   | accepting pixels and writing words while granted
// DRAIN | all pixels taken, emptying the FIFO into SRAM
// DONE  | frame written, waiting for the next start
module rgb_sram_writer #(
  parameter logic [17:0] RGB_BASE_ADDR = 18'd146944,
  parameter int          NUM_PIXELS    = 76800,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic signed [31:0] pix_r,
  input  logic signed [31:0] pix_g,
  input  logic signed [31:0] pix_b,
  input  logic               sram_grant,
  output logic [17:0]        sram_address,
  output logic [15:0]        sram_write_data,
  output logic               sram_we_n,
  output logic               busy,
  output logic               done
);
  localparam int NUM_WORDS = NUM_PIXELS * 3 / 2;
  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] pix_cnt;
  logic [CW-1:0] word_cnt;
  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_1;
  logic [OW-1:0] fifo_cnt;
  logic [OW-1:0] n_push;
  logic          parity;
  logic [7:0]    b_hold;
  logic [7:0]    r_c;
  logic [7:0]    g_c;
  logic [7:0]    b_c;
  logic          push;
  logic          pop;

  function automatic logic [7:0] clip(input logic signed [31:0] v);
    if (v < 0) return 8'd0;
    else if (v > 32'sd255) return 8'hFF;
    else return v[7:0];
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) return '0;
    else return p + PW'(1);
  endfunction

  assign r_c      = clip(pix_r);
  assign g_c      = clip(pix_g);
  assign b_c      = clip(pix_b);
  assign wr_ptr_1 = ptr_inc(wr_ptr);

  // Two free entries are required so an odd pixel can always land both words.
  assign pix_ready = (state == RUN) && (fifo_cnt <= OW'(FIFO_DEPTH - 2)) &&
                     (pix_cnt < CW'(NUM_PIXELS));
  assign push   = pix_valid && pix_ready;
  assign pop    = ((state == RUN) || (state == DRAIN)) && sram_grant && (fifo_cnt != '0);
  assign n_push = !push ? '0 : (parity ? OW'(2) : OW'(1));
  assign busy   = (state == RUN) || (state == DRAIN);
  assign done   = (state == DONE);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state           <= IDLE;
      pix_cnt         <= '0;
      word_cnt        <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      parity          <= 1'b0;
      b_hold          <= 8'd0;
      sram_we_n       <= 1'b1;
      sram_address    <= 18'd0;
      sram_write_data <= 16'd0;
    end else begin
      sram_we_n <= 1'b1;
      if (pop) begin
        sram_we_n       <= 1'b0;
        sram_write_data <= fifo_mem[rd_ptr];
        sram_address    <= RGB_BASE_ADDR + 18'(word_cnt);
        rd_ptr          <= ptr_inc(rd_ptr);
        word_cnt        <= word_cnt + CW'(1);
      end
      if (push) begin
        pix_cnt <= pix_cnt + CW'(1);
        if (!parity) begin
          fifo_mem[wr_ptr] <= {r_c, g_c};
          b_hold           <= b_c;
          wr_ptr           <= wr_ptr_1;
          parity           <= 1'b1;
        end else begin
          fifo_mem[wr_ptr]   <= {b_hold, r_c};
          fifo_mem[wr_ptr_1] <= {g_c, b_c};
          wr_ptr             <= ptr_inc(wr_ptr_1);
          parity             <= 1'b0;
        end
      end
      fifo_cnt <= fifo_cnt + n_push - OW'(pop);

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            pix_cnt  <= '0;
            word_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            parity   <= 1'b0;
            b_hold   <= 8'd0;
          end
        end
        RUN: begin
          if (pix_cnt == CW'(NUM_PIXELS)) state <= DRAIN;
        end
        DRAIN: begin
          // The final pop has already registered its write by the time the FIFO reads empty.
          if ((fifo_cnt == '0) && (word_cnt == CW'(NUM_WORDS))) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
